serial_alu: RTL and testbench
=============================

# serial_alu

Bit-serial ALU sequencer: accepts a WIDTH-bit operand pair and a 3-bit ALU control code, then evaluates the operation one bit per clock, LSB first. It uses the same 1-bit slice semantics as our gate-level ALU: B inverted when subtracting, and a registered carry fed back between bits. It produces the full result plus NZCV flags behind a valid/ready handshake. It is the low-area execute option for the multi-cycle datapath and the driver side of the 1-bit slice interface.

## Interface
- WIDTH, 64, operand/result width in bits; legal range 2..64.
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE; the request is accepted on an edge where in_valid and in_ready are both high.
- cntrl  input  3  operation code: 000 pass B, 010 A+B, 011 A−B, 100 AND, 101 OR, 110 XOR, 001/111 constant 0.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid; held until taken.
- out_ready  input  1  consumer accepts the result on an edge where out_valid and out_ready are both high.
- result  output  WIDTH  operation result.
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.
- carry_out  output  1  carry out of the MSB (arithmetic codes only; else 0).
- overflow  output  1  signed overflow (arithmetic codes only; else 0).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On accept, latch A, B and cntrl into internal registers, clear the bit counter, load carry = (cntrl==011), then go to RUN.
- RUN: each cycle processes bit i = counter.
  - b' = B[i] XOR sub, where sub = (cntrl==011).
  - sum = A[i]^b'^carry; carry <= majority(A[i], b', carry).
  - The result bit is selected by cntrl exactly as in the slice table; AND/OR/XOR use the un-inverted B[i].
  - The result bit shifts into the result register from the MSB end (right shift), so result is LSB-aligned after WIDTH shifts.
  - On the last bit (counter == WIDTH-1), record c_in_msb = carry before update and carry_out = carry after update, then go to DONE.
- DONE: out_valid=1.
  - overflow = c_in_msb XOR carry_out for codes 010/011, else 0; carry_out forced 0 for non-arithmetic codes.
  - N and Z are derived from the final result.
  - On out_valid & out_ready, go to IDLE.
- Subtract convention: carry_out=1 means no borrow (A ≥ B unsigned).
- Operand inputs and cntrl are ignored outside the accept edge. in_valid during RUN or DONE is not accepted and is not queued.
- Codes 001/111 still run WIDTH cycles: result 0, Z=1, N=C=V=0.
- The counter is $clog2(WIDTH) bits and does not wrap; the exit condition is equality to WIDTH-1.

## Timing
- Reset (async assert, any state): state IDLE, in_ready=1, out_valid=0, result=0, negative=0, zero=1, carry_out=0, overflow=0, counter=0, carry=0.
  - A reset mid-RUN or mid-DONE discards the operation; no partial result is ever presented.
- Latency: accept at edge E0; bits processed at E1..E_WIDTH; out_valid high after E_WIDTH (exactly WIDTH cycles after accept).
- Result, flags and out_valid are stable while out_valid=1 and out_ready=0.
- Release: out_ready high at edge E_WIDTH+1 → IDLE, in_ready=1 after that edge.
  - Next accept is earliest at E_WIDTH+2. Peak throughput is one operation per WIDTH+2 cycles.
- out_ready is ignored while out_valid=0. There is no combinational path from in_valid/out_ready to any output.

## Test plan
- ADD, WIDTH=64: A=5, B=3, cntrl=010 → result=8, N=0, Z=0, C=0, V=0; out_valid rises exactly 64 cycles after the accept edge.
- SUB borrow: A=3, B=5, cntrl=011 → result=0xFFFF_FFFF_FFFF_FFFE, N=1, Z=0, C=0, V=0.
- SUB signed overflow: A=0x8000_0000_0000_0000, B=1 → result=0x7FFF_FFFF_FFFF_FFFF, N=0, C=1, V=1. Also A=B=0x1234 → result 0, Z=1, C=1.
- Logic and pass codes: A=0xF0F0, B=0xFF00 → AND 0xF000, OR 0xFFF0, XOR 0x0FF0, pass-B 0xFF00, each with C=V=0. Code 001 and code 111 → result 0, Z=1.
- Backpressure and ignored requests: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid, A and B. Required: outputs unchanged, in_ready=0, no second operation starts. After release, in_ready=1 one cycle later.
- Reset mid-run: assert reset_n=0 at bit 20 of an ADD → out_valid=0 and in_ready=1 immediately, with all outputs at reset values. After reset deasserts, a new A=0xFFFF_FFFF_FFFF_FFFF, B=1 ADD gives result 0, Z=1, C=1, V=0.

Source files
------------

// File: rtl/serial_alu.sv
// Bit-serial ALU: evaluates a WIDTH-bit operation one bit per clock, LSB first,
// using a single add/logic slice with a registered carry, and returns result + NZCV.
module serial_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cntrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready=1
  // RUN   | processing bit cnt_q of the latched operands
  // DONE  | result and flags presented until out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, c_q, v_q;

  logic a_bit, b_bit, b_inv, sub, arith, sum, carry_nx, res_bit, last;

  assign a_bit    = a_q[cnt_q];
  assign b_bit    = b_q[cnt_q];
  assign sub      = (op_q == 3'b011);
  assign arith    = (op_q[2:1] == 2'b01);
  assign b_inv    = b_bit ^ sub;
  assign sum      = a_bit ^ b_inv ^ carry_q;
  assign carry_nx = (a_bit & b_inv) | (a_bit & carry_q) | (b_inv & carry_q);
  assign last     = (cnt_q == LAST);

  always_comb begin
    res_bit = 1'b0;
    case (op_q)
      3'b000:  res_bit = b_bit;
      3'b010,
      3'b011:  res_bit = sum;
      3'b100:  res_bit = a_bit & b_bit;
      3'b101:  res_bit = a_bit | b_bit;
      3'b110:  res_bit = a_bit ^ b_bit;
      default: res_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      a_q     <= A;
      b_q     <= B;
      op_q    <= cntrl;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= (cntrl == 3'b011);
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (state_q == RUN) begin
      // shift in from the MSB so the word is LSB-aligned after WIDTH bits
      res_q   <= {res_bit, res_q[WIDTH-1:1]};
      carry_q <= carry_nx;
      if (!last) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        c_q <= arith & carry_nx;
        v_q <= arith & (carry_q ^ carry_nx);
      end
    end
  end

  // outputs are masked outside DONE so a partial word is never visible
  assign result    = out_valid ? res_q : '0;
  assign negative  = out_valid & res_q[WIDTH-1];
  assign zero      = ~out_valid | (res_q == '0);
  assign carry_out = out_valid & c_q;
  assign overflow  = out_valid & v_q;

endmodule

// File: tb/tb_serial_alu.sv
// Testbench for serial_alu: directed and random operations checked against an
// arithmetic reference model, with backpressure and mid-run reset.
module tb_serial_alu;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   cntrl = 3'b000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         negative, zero, carry_out, overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_r;
  logic         exp_n, exp_z, exp_c, exp_v;
  logic         chk_en = 1'b0;

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cntrl(cntrl), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .negative(negative), .zero(zero), .carry_out(carry_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // reference model: whole-word arithmetic, flags from the sign rules
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    logic [W:0] s;
    s = '0;
    exp_c = 1'b0;
    exp_v = 1'b0;
    case (c)
      3'b000: exp_r = b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        exp_r = s[W-1:0];
        exp_c = s[W];
        exp_v = (a[W-1] == b[W-1]) && (exp_r[W-1] != a[W-1]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        exp_r = s[W-1:0];
        exp_c = s[W];
        exp_v = (a[W-1] != b[W-1]) && (exp_r[W-1] != a[W-1]);
      end
      3'b100: exp_r = a & b;
      3'b101: exp_r = a | b;
      3'b110: exp_r = a ^ b;
      default: exp_r = '0;
    endcase
    exp_n = exp_r[W-1];
    exp_z = (exp_r == '0);
  endtask

  // compare process: every cycle the result is presented
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {63'b0, out_valid}, 64'd1);
      check("result", result, exp_r);
      check("nzcv", {60'b0, negative, zero, carry_out, overflow},
            {60'b0, exp_n, exp_z, exp_c, exp_v});
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                        input int hold, input bit lit, input logic [W-1:0] lit_r,
                        input logic [3:0] lit_nzcv);
    int lat;
    model(a, b, c);
    if (lit) begin
      check("model_r", exp_r, lit_r);
      check("model_nzcv", {60'b0, exp_n, exp_z, exp_c, exp_v}, {60'b0, lit_nzcv});
    end
    @(negedge clk);
    A = a; B = b; cntrl = c; in_valid = 1'b1;
    check("in_ready_idle", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = rnd64(); B = rnd64(); cntrl = 3'($urandom());
    lat = 0;
    while (!out_valid && lat < 200) begin
      in_valid = 1'($urandom());
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(W));
    chk_en = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom()); A = rnd64(); B = rnd64(); cntrl = 3'($urandom());
      check("in_ready_done", {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_en = 1'b0;
    check("release", {62'b0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_valid", {62'b0, in_ready, out_valid}, 64'b10);
    check("rst_result", result, '0);
    check("rst_flags", {60'b0, negative, zero, carry_out, overflow}, 64'b0100);
    @(negedge clk); reset_n = 1'b1;

    run_op(64'd5, 64'd3, 3'b010, 0, 1, 64'd8, 4'b0000);
    run_op(64'd3, 64'd5, 3'b011, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    run_op(64'h8000_0000_0000_0000, 64'd1, 3'b011, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    run_op(64'h1234, 64'h1234, 3'b011, 0, 1, 64'd0, 4'b0110);
    run_op(64'hF0F0, 64'hFF00, 3'b100, 0, 1, 64'hF000, 4'b0000);
    run_op(64'hF0F0, 64'hFF00, 3'b101, 0, 1, 64'hFFF0, 4'b0000);
    run_op(64'hF0F0, 64'hFF00, 3'b110, 0, 1, 64'h0FF0, 4'b0000);
    run_op(64'hF0F0, 64'hFF00, 3'b000, 0, 1, 64'hFF00, 4'b0000);
    run_op(64'hF0F0, 64'hFF00, 3'b001, 0, 1, 64'd0, 4'b0100);
    run_op(64'hF0F0, 64'hFF00, 3'b111, 0, 1, 64'd0, 4'b0100);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 10, 1, 64'h8000_0000_0000_0000, 4'b1001);

    for (int k = 0; k < 30; k++)
      run_op(rnd64(), rnd64(), 3'($urandom()), int'($urandom_range(0, 3)), 0, '0, 4'b0);

    // reset at bit 20 of an ADD
    @(negedge clk);
    A = rnd64(); B = rnd64(); cntrl = 3'b010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    check("midrst_ready_valid", {62'b0, in_ready, out_valid}, 64'b10);
    check("midrst_result", result, '0);
    check("midrst_flags", {60'b0, negative, zero, carry_out, overflow}, 64'b0100);
    @(negedge clk); reset_n = 1'b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 2, 1, 64'd0, 4'b0110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
